// File: rtl/pipeline_trace_buffer.sv
// Pre/post-trigger trace capture for the pipeline probe buses: samples land in a
// circular buffer with a cycle stamp, then stream out oldest-first over valid/ready.
module pipeline_trace_buffer #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int CYCLE_W  = 16,
  localparam int PW       = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic                      sample_en,
  input  logic                      arm,
  input  logic                      trigger,
  input  logic                      abort,
  input  logic [PW-1:0]             post_count,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [CHANNELS*WIDTH-1:0] rd_data,
  output logic [CYCLE_W-1:0]        rd_cycle,
  output logic                      rd_is_trig,
  output logic [1:0]                state,
  output logic [PW-1:0]             fill
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              DW       = CHANNELS * WIDTH;
  localparam logic [PW-1:0]   DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0]   POST_MAX = PW'(DEPTH - 1);
  localparam logic [PW-1:0]   ONE      = PW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               st;
  logic [DW-1:0]        mem_data  [DEPTH];
  logic [CYCLE_W-1:0]   mem_cycle [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        trig_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [PW-1:0]        post_cnt;
  logic [PW-1:0]        remaining;
  logic [PW-1:0]        fill_inc;
  logic [PW-1:0]        post_load;
  logic [CYCLE_W-1:0]   counter;
  logic                 wr_en;

  assign wr_en     = ((st == ARMED) || (st == CAPTURE)) && sample_en;
  assign fill_inc  = (fill == DEPTH_P) ? fill : fill + 1'b1;
  // Clamping keeps the trigger entry from being overwritten by post samples.
  assign post_load = (post_count > POST_MAX) ? POST_MAX : post_count;

  // wr_ptr and fill are frozen in DONE, so the read slot follows from what is left.
  assign rd_ptr     = wr_ptr - remaining[AW-1:0];
  assign rd_valid   = (st == DONE) && (remaining != '0);
  assign rd_data    = rd_valid ? mem_data[rd_ptr] : '0;
  assign rd_cycle   = rd_valid ? mem_cycle[rd_ptr] : '0;
  assign rd_is_trig = rd_valid && (rd_ptr == trig_ptr);
  assign state      = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) counter <= '0;
    else        counter <= counter + 1'b1;
  end

  // NOTE: the storage array has no reset; every entry read back was written first,
  // and leaving it out keeps the array a plain register file without reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr]  <= ch_data;
      mem_cycle[wr_ptr] <= counter;
    end
  end

  // NOTE: state registers use non-blocking assignments so every branch sees the
  // pre-edge values of st, fill and post_cnt, matching the hardware it models.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      remaining <= '0;
    end else if (abort) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      remaining <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill_inc;
      end
      unique case (st)
        IDLE: begin
          wr_ptr <= '0;
          fill   <= '0;
          if (arm) st <= ARMED;
        end
        ARMED: begin
          if (trigger) begin
            // With no sample this cycle the next write lands at wr_ptr anyway.
            trig_ptr <= wr_ptr;
            post_cnt <= post_load;
            if (post_load == '0) begin
              st        <= DONE;
              remaining <= wr_en ? fill_inc : fill;
            end else begin
              st <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == ONE) begin
              st        <= DONE;
              remaining <= fill_inc;
            end
          end
        end
        DONE: begin
          if (remaining == '0) begin
            st     <= IDLE;
            wr_ptr <= '0;
            fill   <= '0;
          end else if (rd_ready) begin
            remaining <= remaining - 1'b1;
            if (remaining == ONE) begin
              st     <= IDLE;
              wr_ptr <= '0;
              fill   <= '0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: directed scenarios plus randomized captures, all
// checked against a queue-based model of the capture/readout behaviour.
module tb_pipeline_trace_buffer;

  localparam int CH = 2;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = 16;
  localparam int PW = $clog2(D) + 1;
  localparam int DW = CH * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] ch_data = '0;
  logic          sample_en = 1'b0;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] post_count = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] rd_cycle;
  logic          rd_is_trig;
  logic [1:0]    state;
  logic [PW-1:0] fill;

  pipeline_trace_buffer #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .CYCLE_W(CW)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .sample_en(sample_en), .arm(arm),
    .trigger(trigger), .abort(abort), .post_count(post_count), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_cycle(rd_cycle), .rd_is_trig(rd_is_trig),
    .state(state), .fill(fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] stamp;
    bit            trig;
  } entry_t;

  entry_t        q[$];
  int            m_state = 0;
  int            m_post = 0;
  bit            m_pend = 1'b0;
  int            m_fill = 0;
  logic [CW-1:0] m_cnt = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_post  = 0;
    m_pend  = 1'b0;
    m_fill  = 0;
    m_cnt   = '0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] s, input bit t);
    entry_t e;
    e.data = d; e.stamp = s; e.trig = t;
    q.push_back(e);
    if (q.size() > D) void'(q.pop_front());
    m_fill = q.size();
  endtask

  task automatic check_outputs(input string tag);
    bit v;
    v = (m_state == 3) && (q.size() > 0);
    check({tag, ".state"}, 64'(state), 64'(m_state));
    check({tag, ".fill"}, 64'(fill), 64'(m_fill));
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(v));
    check({tag, ".rd_data"}, 64'(rd_data), v ? 64'(q[0].data) : 64'd0);
    check({tag, ".rd_cycle"}, 64'(rd_cycle), v ? 64'(q[0].stamp) : 64'd0);
    check({tag, ".rd_is_trig"}, 64'(rd_is_trig), v ? 64'(q[0].trig) : 64'd0);
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check after the rise.
  task automatic cyc(input string tag, input bit a, input bit tg, input bit se, input int pc,
                     input bit ab, input bit rdy, input logic [DW-1:0] d);
    logic [CW-1:0] stamp;
    int ld;
    @(negedge clk);
    arm = a; trigger = tg; sample_en = se; post_count = PW'(pc);
    abort = ab; rd_ready = rdy; ch_data = d;
    stamp = m_cnt;
    m_cnt = m_cnt + 1'b1;
    if (ab) begin
      q.delete(); m_state = 0; m_fill = 0; m_pend = 1'b0;
    end else begin
      case (m_state)
        0: if (a) m_state = 1;
        1: begin
          if (se) push(d, stamp, 1'b0);
          if (tg) begin
            ld = (pc > D - 1) ? D - 1 : pc;
            if (se) q[q.size()-1].trig = 1'b1;
            else    m_pend = 1'b1;
            if (ld == 0) m_state = 3;
            else begin m_post = ld; m_state = 2; end
          end
        end
        2: if (se) begin
          push(d, stamp, m_pend);
          m_pend = 1'b0;
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        default: begin
          if (q.size() == 0) begin
            m_state = 0; m_fill = 0;
          end else if (rdy) begin
            void'(q.pop_front());
            if (q.size() == 0) begin m_state = 0; m_fill = 0; end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // Read everything out; mode 0 = always ready, 1 = fixed stall pattern, 2 = random.
  task automatic drain(input string tag, input int mode, output int hs);
    bit bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit rdy;
    hs = 0;
    for (int k = 0; k < 64 && m_state == 3; k++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bp_pat[k % 6] : 1'($urandom % 2);
      if (rd_valid && rdy) hs++;
      cyc(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0, rdy, rnd_data());
    end
    check({tag, ".idle_after"}, 64'(state), 64'd0);
  endtask

  initial begin
    int hs;
    int posts;
    int npre;
    int pc;
    bit se;

    // Reset held with arm/trigger toggling: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      arm = 1'(i % 2); trigger = 1'((i + 1) % 2);
      @(posedge clk);
      #1;
      check("rst.state", 64'(state), 64'd0);
      check("rst.fill", 64'(fill), 64'd0);
      check("rst.rd_valid", 64'(rd_valid), 64'd0);
      check("rst.rd_data", 64'(rd_data), 64'd0);
      check("rst.rd_cycle", 64'(rd_cycle), 64'd0);
      check("rst.rd_is_trig", 64'(rd_is_trig), 64'd0);
    end
    arm = 1'b0; trigger = 1'b0;
    reset = 1'b1;
    model_reset();

    // Wrap: 16 samples into 8 entries, trigger on sample 12 with 3 post samples.
    cyc("wrap.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 16; s++)
      cyc("wrap.cap", 1'b0, s == 12, 1'b1, 3, 1'b0, 1'b0, DW'(s));
    check("wrap.fill8", 64'(fill), 64'd8);
    check("wrap.first", 64'(rd_data[W-1:0]), 64'd8);
    drain("wrap.rd", 0, hs);
    check("wrap.handshakes", 64'(hs), 64'd8);

    // Short capture: post_count 0 finishes on the trigger sample.
    cyc("short.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 3; s++)
      cyc("short.cap", 1'b0, s == 2, 1'b1, 0, 1'b0, 1'b0, DW'(s));
    check("short.fill3", 64'(fill), 64'd3);
    check("short.done", 64'(state), 64'd3);
    drain("short.rd", 0, hs);
    check("short.handshakes", 64'(hs), 64'd3);
    check("short.rd_valid_after", 64'(rd_valid), 64'd0);

    // Backpressure: stalled entries must hold; exactly 8 handshakes.
    cyc("bp.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 10; s++)
      cyc("bp.cap", 1'b0, s == 9, 1'b1, 0, 1'b0, 1'b0, rnd_data());
    drain("bp.rd", 1, hs);
    check("bp.handshakes", 64'(hs), 64'd8);

    // Clamp plus gaps: post_count 15 clamps to 7 with half-duty sampling.
    cyc("clamp.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 10; s++)
      cyc("clamp.pre", 1'b0, s == 9, 1'b1, 15, 1'b0, 1'b0, rnd_data());
    posts = 0;
    for (int k = 0; k < 100 && m_state == 2; k++) begin
      se = 1'($urandom % 2);
      if (state == 2'd2 && se) posts++;
      cyc("clamp.post", 1'b0, 1'b0, se, 15, 1'b0, 1'b0, rnd_data());
    end
    check("clamp.posts", 64'(posts), 64'd7);
    check("clamp.trig_first", 64'(rd_is_trig), 64'd1);
    drain("clamp.rd", 2, hs);
    check("clamp.handshakes", 64'(hs), 64'd8);

    // Abort during capture, arm+abort in IDLE, trigger in IDLE.
    cyc("abort.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 4; s++)
      cyc("abort.cap", 1'b0, s == 2, 1'b1, 5, 1'b0, 1'b0, rnd_data());
    check("abort.in_capture", 64'(state), 64'd2);
    cyc("abort.hit", 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, rnd_data());
    check("abort.fill0", 64'(fill), 64'd0);
    cyc("abort.arm_abort", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, '0);
    check("abort.stays_idle", 64'(state), 64'd0);
    cyc("abort.trig_idle", 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, rnd_data());

    // Randomized captures with random gaps, ignored controls and random backpressure.
    for (int r = 0; r < 20; r++) begin
      cyc("rnd.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
      npre = $urandom_range(0, 20);
      for (int s = 0; s < npre; s++)
        cyc("rnd.pre", 1'b0, 1'b0, 1'($urandom % 2), 0, 1'b0, 1'b0, rnd_data());
      pc = $urandom_range(0, 15);
      se = (pc == 0) ? 1'b1 : 1'($urandom % 2);
      cyc("rnd.trig", 1'($urandom % 2), 1'b1, se, pc, 1'b0, 1'b0, rnd_data());
      for (int k = 0; k < 200 && m_state == 2; k++)
        cyc("rnd.post", 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
            $urandom_range(0, 15), 1'b0, 1'($urandom % 2), rnd_data());
      check("rnd.reached_done", 64'(state), 64'd3);
      drain("rnd.rd", 2, hs);
    end

    // Reset asserted mid-readout drops rd_valid without waiting for a clock.
    cyc("rmid.arm", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 4; s++)
      cyc("rmid.cap", 1'b0, s == 3, 1'b1, 0, 1'b0, 1'b0, rnd_data());
    check("rmid.valid_before", 64'(rd_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rmid.valid_async", 64'(rd_valid), 64'd0);
    check("rmid.state_async", 64'(state), 64'd0);
    arm = 1'b0; trigger = 1'b0; sample_en = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    cyc("rmid.after", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_trace_buffer.md
# pipeline_trace_buffer

Synthesizable, parametrised trace capture unit for the MIPS pipeline. It snapshots up to CHANNELS pipeline probe buses (IF/ID/EX/MEM/WB test outputs) every enabled cycle into a circular buffer, with a free-running cycle stamp. Capture runs in pre-trigger/post-trigger mode. Frozen contents are streamed out oldest-first over a valid/ready port. It sits beside `pipeline` at top level, replacing manual cycle-by-cycle waveform inspection in simulation and on hardware.

## Interface
- CHANNELS, 4, number of probe buses captured per sample
- WIDTH, 32, bits per probe bus
- DEPTH, 16, buffer entries; power of two, ≥2
- CYCLE_W, 16, cycle-stamp width
- PW = $clog2(DEPTH)+1 (derived, not overridable)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- ch_data  in  CHANNELS*WIDTH  probe buses; channel i at [i*WIDTH +: WIDTH]
- sample_en  in  1  write a sample this cycle (when capturing)
- arm  in  1  start a capture (honoured in IDLE only)
- trigger  in  1  trigger event (honoured in ARMED only)
- abort  in  1  return to IDLE from any state, discard buffer
- post_count  in  PW  samples to take after the trigger sample; sampled on the trigger cycle
- rd_valid  out  1  rd_data/rd_cycle hold a valid entry
- rd_ready  in  1  consumer accepts entry
- rd_data  out  CHANNELS*WIDTH  entry data
- rd_cycle  out  CYCLE_W  entry cycle stamp
- rd_is_trig  out  1  current entry is the trigger sample
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- fill  out  PW  valid entries in buffer (0..DEPTH)

## Operation
- Cycle counter: increments every clk from 0 after reset; wraps at 2^CYCLE_W; runs in all states.
- Sample write: in ARMED or CAPTURE with sample_en=1, {ch_data, counter} written at wr_ptr; wr_ptr increments mod DEPTH; fill increments, saturating at DEPTH (oldest overwritten).
- IDLE: wr_ptr=0, fill=0. arm=1 → ARMED.
- ARMED: writes as above. trigger=1 → CAPTURE; that cycle's sample (if sample_en) is written and its index recorded as trig_ptr; post counter loaded with min(post_count, DEPTH-1) so the trigger entry is never overwritten. Loaded value 0 → straight to DONE. trigger with sample_en=0 records trig_ptr = index of the next written sample.
- CAPTURE: each written sample decrements the post counter; the write that takes it to 0 moves to DONE. trigger ignored.
- DONE: no writes. rd_ptr = (wr_ptr − fill) mod DEPTH; remaining = fill. rd_valid = (remaining≠0). rd_valid&&rd_ready → rd_ptr+1 mod DEPTH, remaining−1. remaining reaching 0 → IDLE.
- rd_is_trig = rd_valid && rd_ptr==trig_ptr.
- abort=1 → IDLE next edge from any state; fill=0. abort beats arm/trigger on the same cycle.
- arm outside IDLE, trigger outside ARMED: ignored.
- fill reports 0 in IDLE, live count otherwise; in DONE it stays constant (not remaining).

## Timing
- All state and pointer updates on rising clk; reset asynchronous.
- Reset values: state=IDLE, fill=0, rd_valid=0, rd_data=0, rd_cycle=0, rd_is_trig=0, counter=0, pointers=0.
- Storage is a register array; rd_data/rd_cycle are combinational reads at rd_ptr, forced to 0 when rd_valid=0.
- rd_valid rises in the first cycle of DONE (one edge after the final capture write).
- Backpressure: while rd_valid&&!rd_ready, rd_data/rd_cycle/rd_is_trig hold stable. One entry per cycle with rd_ready held high.
- arm→ARMED, trigger→CAPTURE/DONE: 1 cycle.
- Reset mid-readout: rd_valid drops asynchronously; buffer contents are don't-care.

## Test plan
- Reset: hold reset=0 for 3 cycles with arm/trigger toggling → all outputs 0, state=0; release → counter stamps start at 0.
- Wrap: DEPTH=8, CHANNELS=2. arm; sample_en=1 every cycle with ch0=sample index; trigger on sample 12, post_count=3 → fill=8; readout ch0=8..15 in order; rd_is_trig on the 5th entry (12); stamps consecutive.
- Short capture: arm; 2 samples; trigger on 3rd; post_count=0 → DONE immediately, fill=3; readout 0,1,2; rd_valid=0 afterwards, state=IDLE.
- Backpressure: in DONE, rd_ready pattern 1,0,0,1,0,1… → each entry held stable while stalled; no entry lost or duplicated; 8 handshakes total.
- Clamp plus gaps: post_count=15 (clamped to 7), sample_en 50% duty → exactly 7 post samples written; trigger entry is first read; stamps non-consecutive, matching the write cycles.
- Abort/ignore: abort during CAPTURE → IDLE, fill=0 next cycle; arm+abort together in IDLE → stays IDLE; trigger in IDLE → no effect.
